// File: rtl/f_ifu_pkg.sv
// ---------------------------------------------------------------------------
// f_ifu_pkg -- shared pipeline constants and types for the fetch stage.
//
// Contents:
//   PC_RESET   : fetch address after reset
//   IM_BASE    : lowest valid instruction address
//   IM_END     : highest valid (word-aligned) instruction address
//   EXC_NONE   : exception code meaning "no exception"
//   EXC_ADEL   : address-error-on-load code used for bad fetch addresses
//   fd_payload_t : contents of the F/D pipeline register
//   fetch_addr_bad() : true when a fetch address is misaligned or out of range
// ---------------------------------------------------------------------------
package f_ifu_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_END   = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc_code;
    } fd_payload_t;

    // Word alignment plus inclusive range check against the instruction memory window.
    function automatic logic fetch_addr_bad(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_END);
    endfunction

endpackage

// File: rtl/fd_reg.sv
// ---------------------------------------------------------------------------
// fd_reg -- F/D pipeline register.
//
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset (highest priority)
//   stall   : hold the register contents
//   clear   : load a bubble (instr = 0, no exception) but keep the PC;
//             wins over stall
//   fd_in   : payload from the fetch stage
//   fd_out  : registered payload presented to decode
// ---------------------------------------------------------------------------
module fd_reg
    import f_ifu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        clear,
    input  fd_payload_t fd_in,
    output fd_payload_t fd_out
);

    fd_payload_t fd_reg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fd_reg_q.pc       <= PC_RESET;
            fd_reg_q.instr    <= 32'h0;
            fd_reg_q.exc_code <= EXC_NONE;
        end else if (clear) begin
            // The bubble keeps the fetch PC so later stages can still
            // attribute the slot to an address.
            fd_reg_q.pc       <= fd_in.pc;
            fd_reg_q.instr    <= 32'h0;
            fd_reg_q.exc_code <= EXC_NONE;
        end else if (!stall) begin
            fd_reg_q <= fd_in;
        end
    end

    assign fd_out = fd_reg_q;

endmodule

// File: rtl/f_ifu.sv
// ---------------------------------------------------------------------------
// f_ifu -- instruction fetch unit: PC register, fetch exception check and
// the F/D pipeline register.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   Stall      : hold PC and F/D register
//   Clear      : load a bubble into the F/D register (F_PC still obeys Stall)
//   Npc        : next PC, computed in decode (including the +4 case)
//   IM_Addr    : instruction memory address (= F_PC)
//   IM_RData   : combinational instruction memory read data
//   F_PC       : current fetch PC
//   D_PC       : PC of the instruction in the F/D register
//   D_Instr    : instruction in the F/D register
//   D_ExcCode  : fetch exception code carried to decode (0 = none)
//
// Build option:
//   F_IFU_ADEL_EN : when defined, misaligned or out-of-window fetch addresses
//                   raise AdEL (code 4) and the fetched word becomes a nop.
//                   When undefined, D_ExcCode is always 0 and IM_RData is
//                   passed through untouched.
// ---------------------------------------------------------------------------
module f_ifu
    import f_ifu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Clear,
    input  logic [31:0] Npc,
    output logic [31:0] IM_Addr,
    input  logic [31:0] IM_RData,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic [4:0]  D_ExcCode
);

    logic [31:0] pc_reg;
    logic [31:0] f_instr;
    logic [4:0]  f_exc_code;
    fd_payload_t fd_next;
    fd_payload_t fd_cur;

    // The PC never increments on its own: decode supplies every next address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= PC_RESET;
        end else if (!Stall) begin
            pc_reg <= Npc;
        end
    end

    assign F_PC    = pc_reg;
    assign IM_Addr = pc_reg;

`ifdef F_IFU_ADEL_EN
    logic f_adel;

    always_comb begin
        f_adel     = fetch_addr_bad(pc_reg);
        f_instr    = f_adel ? 32'h0 : IM_RData;
        f_exc_code = f_adel ? EXC_ADEL : EXC_NONE;
    end
`else
    always_comb begin
        f_instr    = IM_RData;
        f_exc_code = EXC_NONE;
    end
`endif

    always_comb begin
        fd_next.pc       = pc_reg;
        fd_next.instr    = f_instr;
        fd_next.exc_code = f_exc_code;
    end

    fd_reg u_fd_reg (
        .clk    (clk),
        .reset  (reset),
        .stall  (Stall),
        .clear  (Clear),
        .fd_in  (fd_next),
        .fd_out (fd_cur)
    );

    assign D_PC      = fd_cur.pc;
    assign D_Instr   = fd_cur.instr;
    assign D_ExcCode = fd_cur.exc_code;

endmodule

// File: tb/tb_f_ifu.sv
// ---------------------------------------------------------------------------
// tb_f_ifu -- scoreboard bench for f_ifu.
// The stimulus process drives one cycle of inputs and queues the state it
// expects after the next rising edge; the monitor pops one entry at each
// falling edge and compares it with the DUT outputs.
// Instruction memory model: word at address a is 32'hA5A5_0000 ^ a.
// ---------------------------------------------------------------------------
module tb_f_ifu;

    typedef struct {
        string       name;
        logic [31:0] f_pc;
        logic [31:0] d_pc;
        logic [31:0] d_instr;
        logic [4:0]  d_exc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Clear;
    logic [31:0] Npc;
    logic [31:0] IM_Addr;
    logic [31:0] IM_RData;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic [4:0]  D_ExcCode;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef F_IFU_ADEL_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif

    f_ifu dut (
        .clk       (clk),
        .reset     (reset),
        .Stall     (Stall),
        .Clear     (Clear),
        .Npc       (Npc),
        .IM_Addr   (IM_Addr),
        .IM_RData  (IM_RData),
        .F_PC      (F_PC),
        .D_PC      (D_PC),
        .D_Instr   (D_Instr),
        .D_ExcCode (D_ExcCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign IM_RData = 32'hA5A5_0000 ^ IM_Addr;

    task automatic cmp32(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s %s actual=%08h required=%08h", name, field, act, req);
        end
    endtask

    // Monitor: one transaction per falling edge while expectations are queued.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp32(e.name, "F_PC",      F_PC,             e.f_pc);
            cmp32(e.name, "IM_Addr",   IM_Addr,          e.f_pc);
            cmp32(e.name, "D_PC",      D_PC,             e.d_pc);
            cmp32(e.name, "D_Instr",   D_Instr,          e.d_instr);
            cmp32(e.name, "D_ExcCode", {27'h0, D_ExcCode}, {27'h0, e.d_exc});
            $display("txn %-14s F_PC=%08h D_PC=%08h D_Instr=%08h D_ExcCode=%0d",
                     e.name, F_PC, D_PC, D_Instr, D_ExcCode);
        end
    end

    // Drive one cycle and queue the expected state after the coming edge.
    task automatic step(input string name, input logic r, input logic s,
                        input logic c, input logic [31:0] npc,
                        input logic [31:0] ef, input logic [31:0] edpc,
                        input logic [31:0] edi, input logic [4:0] eexc);
        exp_t e;
        reset = r;
        Stall = s;
        Clear = c;
        Npc   = npc;
        @(posedge clk);
        #1;
        e.name    = name;
        e.f_pc    = ef;
        e.d_pc    = edpc;
        e.d_instr = edi;
        e.d_exc   = eexc;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [31:0] bad_i;
        logic [4:0]  bad_e;
        bad_e = ADEL ? 5'd4 : 5'd0;

        // Reset state
        step("reset0", 1, 0, 0, 32'h3004, 32'h3000, 32'h3000, 32'h0, 0);
        step("reset1", 1, 0, 0, 32'h3004, 32'h3000, 32'h3000, 32'h0, 0);
        // First fetch after release
        step("fetch3000", 0, 0, 0, 32'h3004, 32'h3004, 32'h3000, 32'hA5A5_3000, 0);
        step("fetch3004", 0, 0, 0, 32'h3008, 32'h3008, 32'h3004, 32'hA5A5_3004, 0);
        // Clear at F_PC=0x3008
        step("clear3008", 0, 0, 1, 32'h300C, 32'h300C, 32'h3008, 32'h0, 0);
        // Stall+Clear at F_PC=0x300C: PC holds, bubble loaded
        step("stallclr", 0, 1, 1, 32'h3010, 32'h300C, 32'h300C, 32'h0, 0);
        step("fetch300C", 0, 0, 0, 32'h3010, 32'h3010, 32'h300C, 32'hA5A5_300C, 0);
        step("fetch3010", 0, 0, 0, 32'h3014, 32'h3014, 32'h3010, 32'hA5A5_3010, 0);
        // Three stall cycles with Npc=0x3010: nothing moves
        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 0, 32'h3010, 32'h3014, 32'h3010, 32'hA5A5_3010, 0);
        step("release", 0, 0, 0, 32'h3010, 32'h3010, 32'h3014, 32'hA5A5_3014, 0);
        step("to3020", 0, 0, 0, 32'h3020, 32'h3020, 32'h3010, 32'hA5A5_3010, 0);
        // Reset during stall at F_PC=0x3020
        step("rst_in_stall", 1, 1, 0, 32'h3024, 32'h3000, 32'h3000, 32'h0, 0);
        step("restart", 0, 0, 0, 32'h3004, 32'h3004, 32'h3000, 32'hA5A5_3000, 0);
        // Address-error checks
        step("to3002", 0, 0, 0, 32'h3002, 32'h3002, 32'h3004, 32'hA5A5_3004, 0);
        bad_i = ADEL ? 32'h0 : 32'hA5A5_3002;
        step("misalign", 0, 0, 0, 32'h7000, 32'h7000, 32'h3002, bad_i, bad_e);
        bad_i = ADEL ? 32'h0 : 32'hA5A5_7000;
        step("above_end", 0, 0, 0, 32'h6FFC, 32'h6FFC, 32'h7000, bad_i, bad_e);
        step("at_end", 0, 0, 0, 32'h2FFC, 32'h2FFC, 32'h6FFC, 32'hA5A5_6FFC, 0);
        bad_i = ADEL ? 32'h0 : 32'hA5A5_2FFC;
        step("below_base", 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h2FFC, bad_i, bad_e);
        bad_i = ADEL ? 32'h0 : 32'h5A5A_FFFC;
        step("top_addr", 0, 0, 0, 32'h3000, 32'h3000, 32'hFFFF_FFFC, bad_i, bad_e);
        step("at_base", 0, 0, 0, 32'h3004, 32'h3004, 32'h3000, 32'hA5A5_3000, 0);

        // Let the monitor drain, bounded to a few cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f_ifu.md
F_IFU -- requirements
Module: f_ifu

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port Stall, input, 1, hold PC and F/D register this cycle.
REQ-004 SHALL have port Clear, input, 1, load a bubble (nop) into the F/D register this cycle.
REQ-005 SHALL have port Npc, input, 32, next PC from D-stage NPC logic.
REQ-006 SHALL have port IM_Addr, output, 32, instruction-memory word address, equal to F_PC.
REQ-007 SHALL have port IM_RData, input, 32, combinational instruction-memory read data for IM_Addr.
REQ-008 SHALL have port F_PC, output, 32, current fetch PC.
REQ-009 SHALL have port D_PC, output, 32, PC of the instruction held in the F/D register.
REQ-010 SHALL have port D_Instr, output, 32, instruction held in the F/D register.
REQ-011 SHALL have port D_ExcCode, output, 5, fetch exception code carried into D; 0 means none.

Function
REQ-012 SHALL hold F_PC in a 32-bit register; IM_Addr SHALL be F_PC combinationally.
REQ-013 SHALL load F_PC <= Npc on each clk edge when reset=0 and Stall=0.
REQ-014 SHALL keep F_PC unchanged when Stall=1, regardless of the Npc value.
REQ-015 SHALL load D_PC <= F_PC, D_Instr <= fetched word, and D_ExcCode <= F-stage code on each edge when Stall=0 and Clear=0 (latency one cycle F->D).
REQ-016 SHALL load D_Instr <= 32'h0, D_ExcCode <= 0, and D_PC <= F_PC when Clear=1, keeping the PC so that it tracks the bubble.
REQ-017 SHALL hold all of D_PC, D_Instr, and D_ExcCode unchanged when Stall=1 and Clear=0.
REQ-018 SHALL, when Stall=1 and Clear=1 together, let Clear win for the F/D register while F_PC still holds.
REQ-019 SHALL not increment the PC itself; Npc (including the F_PC+4 case) comes from the D stage only.
REQ-020 SHALL use 32-bit PC arithmetic with natural wrap; no PC saturation.

Reset
REQ-021 SHALL set F_PC = 32'h0000_3000 on reset.
REQ-022 SHALL set D_PC = 32'h0000_3000, D_Instr = 32'h0, and D_ExcCode = 0 on reset.
REQ-023 SHALL give reset priority over Stall and Clear; a mid-stall reset restarts at 0x3000 on the next edge.

Configuration
REQ-024 SHALL recognise macro F_IFU_ADEL_EN.
REQ-025 SHALL, with F_IFU_ADEL_EN defined, flag a fetch exception when F_PC[1:0] != 0 or F_PC lies outside [0x0000_3000, 0x0000_6FFC]; the F-stage code SHALL then be 5'd4 (AdEL) and the fetched word SHALL be replaced by 32'h0.
REQ-026 SHALL, without F_IFU_ADEL_EN, keep the D_ExcCode port present, always 0, and pass IM_RData through unmodified.

Structure
REQ-027 SHALL place PC_RESET (0x3000), IM_BASE (0x3000), IM_END (0x6FFC), EXC_NONE (0), and EXC_ADEL (4) in the shared pipeline package.
REQ-028 SHALL isolate the F/D register (Stall/Clear/reset priority) in sub-module fd_reg; the PC register and exception check stay in f_ifu.

Verification
REQ-029 SHALL verify: reset then release, Npc=0x3004 -> F_PC=0x3000 first cycle, then 0x3004; D_PC=0x3000 with D_Instr=IM[0x3000] after the first edge.
REQ-030 SHALL verify: Stall=1 for 3 cycles with Npc=0x3010 -> F_PC, D_PC, and D_Instr constant; on release F_PC=0x3010 next edge.
REQ-031 SHALL verify: Clear=1 one cycle at F_PC=0x3008 -> D_Instr=0, D_PC=0x3008, and D_ExcCode=0; fetch continues normally.
REQ-032 SHALL verify: Stall=1 and Clear=1 together at F_PC=0x300C -> F_PC stays 0x300C, D_Instr=0.
REQ-033 SHALL verify: with F_IFU_ADEL_EN, Npc=0x3002 then 0x7000 -> D_ExcCode=4 and D_Instr=0 for each; without the macro -> D_ExcCode=0 and D_Instr=IM_RData.
REQ-034 SHALL verify: reset asserted during Stall=1 at F_PC=0x3020 -> next edge F_PC=0x3000, D_Instr=0.
